// File: rtl/tx_uart_fifo.sv
// UART transmitter with a small write FIFO, runtime parity (none/even/odd)
// and 1/2 stop bits, paced by an external oversampling tick.
module tx_uart_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int N_TICKS    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ticks,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_data_in,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  input  logic                 i_stop2,
  output logic                 o_data_out,
  output logic                 o_tx_done,
  output logic                 o_busy,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [CNT_W-1:0]     o_count,
  output logic                 o_overflow
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int TICK_W = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] shift;
    logic                 par_en;
    logic                 par_bit;
    logic                 stop2;
  } frame_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wptr, r_rptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_overflow;

  state_t               r_state;
  frame_t               r_frame;
  logic [TICK_W-1:0]    r_tick;
  logic [BIT_W-1:0]     r_bit;
  logic                 r_stop_2nd;
  logic                 r_data_out;
  logic                 r_tx_done;

  logic                 w_full, w_empty, w_push, w_pop, w_bit_end;
  logic [DATA_BITS-1:0] w_head;

  // Full is taken from the registered count, so a write while full is
  // dropped even if the FSM pops in the same cycle.
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = i_wr && !w_full;
  assign w_pop     = (r_state == IDLE) && !w_empty;
  assign w_head    = r_mem[r_rptr];
  assign w_bit_end = i_ticks && (r_tick == TICK_W'(N_TICKS - 1));

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data_in;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_wr && w_full;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_frame    <= '0;
      r_tick     <= '0;
      r_bit      <= '0;
      r_stop_2nd <= 1'b0;
      r_data_out <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      if (r_state == IDLE) begin
        if (!w_empty) begin
          // Parity is resolved at pop time so later config changes cannot leak in.
          r_frame    <= '{shift: w_head, par_en: i_parity_en,
                          par_bit: (^w_head) ^ i_parity_odd, stop2: i_stop2};
          r_tick     <= '0;
          r_bit      <= '0;
          r_stop_2nd <= 1'b0;
          r_data_out <= 1'b0;
          r_state    <= START;
        end
      end else if (i_ticks) begin
        if (!w_bit_end) begin
          r_tick <= r_tick + 1'b1;
        end else begin
          r_tick <= '0;
          case (r_state)
            START: begin
              r_state    <= DATA;
              r_data_out <= r_frame.shift[0];
            end
            DATA: begin
              if (r_bit == BIT_W'(DATA_BITS - 1)) begin
                if (r_frame.par_en) begin
                  r_state    <= PARITY;
                  r_data_out <= r_frame.par_bit;
                end else begin
                  r_state    <= STOP;
                  r_data_out <= 1'b1;
                end
              end else begin
                r_bit         <= r_bit + 1'b1;
                r_frame.shift <= r_frame.shift >> 1;
                r_data_out    <= r_frame.shift[1];
              end
            end
            PARITY: begin
              r_state    <= STOP;
              r_data_out <= 1'b1;
            end
            STOP: begin
              if (r_frame.stop2 && !r_stop_2nd) begin
                r_stop_2nd <= 1'b1;
              end else begin
                r_state   <= IDLE;
                r_tx_done <= 1'b1;
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign o_data_out = r_data_out;
  assign o_tx_done  = r_tx_done;
  assign o_busy     = (r_state != IDLE);
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
endmodule

// File: tb/tb_tx_uart_fifo.sv
// Bench for tx_uart_fifo: scoreboard of queued frames decoded off the serial
// line by mid-bit sampling, plus reset/overflow/config-latch scenarios.
module tb_tx_uart_fifo;
  localparam int DB = 8, NT = 16, FD = 4, CW = $clog2(FD) + 1;

  logic          i_clk = 0, i_reset = 1, i_ticks = 0, i_wr = 0;
  logic [DB-1:0] i_data_in = '0;
  logic          i_parity_en = 0, i_parity_odd = 0, i_stop2 = 0;
  logic          o_data_out, o_tx_done, o_busy, o_full, o_empty, o_overflow;
  logic [CW-1:0] o_count;

  tx_uart_fifo #(.DATA_BITS(DB), .N_TICKS(NT), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ticks(i_ticks), .i_wr(i_wr),
    .i_data_in(i_data_in), .i_parity_en(i_parity_en), .i_parity_odd(i_parity_odd),
    .i_stop2(i_stop2), .o_data_out(o_data_out), .o_tx_done(o_tx_done),
    .o_busy(o_busy), .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .o_overflow(o_overflow));

  typedef struct {
    logic [DB-1:0] d;
    bit pen;
    bit podd;
    bit s2;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0, miss = 0;
  int   cyc = 0, last_fall = 0, n_done = 0, n_ov = 0, tick_ph = 0;
  logic prev_line = 1'b1;
  bit   tick_en = 0;

  always #5 i_clk = ~i_clk;

  // Negedge index bookkeeping; tasks read these one negedge late (NBA).
  always @(negedge i_clk) begin
    cyc       <= cyc + 1;
    prev_line <= o_data_out;
    if (prev_line === 1'b1 && o_data_out === 1'b0) last_fall <= cyc + 1;
    if (o_tx_done === 1'b1)  n_done <= n_done + 1;
    if (o_overflow === 1'b1) n_ov   <= n_ov + 1;
  end

  // Oversampling tick every 4 clocks while enabled.
  initial forever begin
    @(negedge i_clk);
    tick_ph = (tick_ph + 1) % 4;
    i_ticks = tick_en && (tick_ph == 0);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: sim time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic wr(input logic [DB-1:0] d);
    @(negedge i_clk);
    i_wr = 1; i_data_in = d;
    sb.push_back('{d, i_parity_en, i_parity_odd, i_stop2});
    @(negedge i_clk);
    i_wr = 0;
  endtask

  // Decode one frame, compare each bit and the done pulse timing.
  task automatic expect_frame(input string nm, input bit from_now);
    exp_t e;
    logic [15:0] wv;
    int nb, base, t, off;
    if (sb.size() == 0) begin
      vecs++; miss++;
      $display("FAIL %s: scoreboard empty, got frame request, want queued word", nm);
      return;
    end
    e = sb.pop_front();
    wv = '0; nb = 0;
    wv[nb] = 1'b0; nb++;
    for (int i = 0; i < DB; i++) begin wv[nb] = e.d[i]; nb++; end
    if (e.pen) begin wv[nb] = (^e.d) ^ e.podd; nb++; end
    wv[nb] = 1'b1; nb++;
    if (e.s2) begin wv[nb] = 1'b1; nb++; end
    t = 0;
    while (o_data_out !== 1'b0 && t < 3000) begin @(negedge i_clk); t++; end
    if (o_data_out !== 1'b0) begin
      vecs++; miss++;
      $display("FAIL %s start: line=%b, want 0 within 3000 clocks", nm, o_data_out);
      return;
    end
    if (from_now) base = cyc + 1;
    else begin @(negedge i_clk); base = last_fall; end
    for (int k = 0; k < nb; k++) begin
      while (cyc + 1 - base < 32 + 64 * k) @(negedge i_clk);
      vecs++;
      if (o_data_out !== wv[k]) begin
        miss++;
        $display("FAIL %s bit%0d: line=%b want=%b", nm, k, o_data_out, wv[k]);
      end
    end
    t = 0;
    while (o_tx_done !== 1'b1 && t < 200) begin @(negedge i_clk); t++; end
    off = cyc + 1 - base;
    vecs++;
    if (o_tx_done !== 1'b1 || (!from_now && (off < nb * 64 - 4 || off > nb * 64 + 1))) begin
      miss++;
      $display("FAIL %s done: done=%b at %0d clocks, want 1 near %0d", nm, o_tx_done, off, nb * 64);
    end
    @(negedge i_clk);
    vecs++;
    if (o_tx_done !== 1'b0) begin
      miss++;
      $display("FAIL %s done_width: done=%b one clock later, want 0", nm, o_tx_done);
    end
  endtask

  task automatic test_reset();
    #2 i_reset = 0;
    #1;
    vecs++; if (o_data_out !== 1'b1) begin miss++; $display("FAIL rst_line: got %b want 1", o_data_out); end
    vecs++; if (o_tx_done !== 1'b0) begin miss++; $display("FAIL rst_done: got %b want 0", o_tx_done); end
    vecs++; if (o_busy !== 1'b0) begin miss++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    vecs++; if (o_full !== 1'b0) begin miss++; $display("FAIL rst_full: got %b want 0", o_full); end
    vecs++; if (o_empty !== 1'b1) begin miss++; $display("FAIL rst_empty: got %b want 1", o_empty); end
    vecs++; if (o_count !== '0) begin miss++; $display("FAIL rst_count: got %0d want 0", o_count); end
    vecs++; if (o_overflow !== 1'b0) begin miss++; $display("FAIL rst_ovf: got %b want 0", o_overflow); end
    repeat (3) @(negedge i_clk);
    i_reset = 1;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_basic();
    int d0;
    d0 = n_done;
    tick_en = 1;
    i_parity_en = 0; i_stop2 = 0;
    wr(8'hA5);
    vecs++; if (o_data_out !== 1'b1) begin miss++; $display("FAIL latency_line: got %b one edge after write, want 1", o_data_out); end
    vecs++; if (o_count !== CW'(1)) begin miss++; $display("FAIL latency_count: got %0d want 1", o_count); end
    expect_frame("a5", 0);
    vecs++; if (o_busy !== 1'b0) begin miss++; $display("FAIL a5_busy: got %b want 0", o_busy); end
    vecs++; if (n_done - d0 !== 1) begin miss++; $display("FAIL a5_ndone: got %0d want 1", n_done - d0); end
  endtask

  task automatic test_parity();
    i_parity_en = 1; i_parity_odd = 0;
    wr(8'h07);
    repeat (3) @(negedge i_clk);
    i_parity_odd = 1;
    wr(8'h07);
    expect_frame("par_even", 0);
    expect_frame("par_odd", 0);
    i_parity_en = 0; i_parity_odd = 0;
  endtask

  task automatic test_stop2();
    i_stop2 = 1;
    wr(8'h3C);
    repeat (3) @(negedge i_clk);
    i_stop2 = 0;
    wr(8'h5A);
    expect_frame("stop2", 0);
    vecs++; if (o_data_out !== 1'b0) begin miss++; $display("FAIL b2b_start: line=%b one clock after done, want 0", o_data_out); end
    expect_frame("after_stop2", 0);
  endtask

  task automatic test_overflow_stall();
    int d0, ov0;
    tick_en = 0;
    repeat (4) @(negedge i_clk);
    d0 = n_done; ov0 = n_ov;
    for (int i = 1; i <= 6; i++) begin
      @(negedge i_clk);
      i_wr = 1; i_data_in = 8'(i);
      if (i <= 5) sb.push_back('{8'(i), i_parity_en, i_parity_odd, i_stop2});
    end
    @(negedge i_clk);
    i_wr = 0;
    repeat (3) @(negedge i_clk);
    vecs++; if (o_full !== 1'b1) begin miss++; $display("FAIL stall_full: got %b want 1", o_full); end
    vecs++; if (o_count !== CW'(4)) begin miss++; $display("FAIL stall_count: got %0d want 4", o_count); end
    vecs++; if (n_ov - ov0 !== 1) begin miss++; $display("FAIL stall_ovf: got %0d pulses want 1", n_ov - ov0); end
    vecs++; if (o_busy !== 1'b1 || o_data_out !== 1'b0) begin
      miss++; $display("FAIL stall_start: busy=%b line=%b want 1/0", o_busy, o_data_out);
    end
    tick_en = 1;
    expect_frame("stall_01", 1);
    for (int i = 2; i <= 5; i++) expect_frame($sformatf("stall_%02x", i), 0);
    vecs++; if (n_done - d0 !== 5) begin miss++; $display("FAIL stall_ndone: got %0d want 5", n_done - d0); end
    vecs++; if (o_empty !== 1'b1) begin miss++; $display("FAIL stall_empty: got %b want 1", o_empty); end
  endtask

  task automatic test_reset_mid();
    int d0, t, lows;
    tick_en = 1;
    wr(8'h55); wr(8'h11); wr(8'h22);
    t = 0;
    while (o_data_out !== 1'b0 && t < 3000) begin @(negedge i_clk); t++; end
    repeat (160) @(negedge i_clk);
    vecs++; if (o_data_out !== 1'b0) begin miss++; $display("FAIL rmid_pre: line=%b in bit1 of 0x55, want 0", o_data_out); end
    d0 = n_done;
    #2 i_reset = 0;
    #1;
    vecs++; if (o_data_out !== 1'b1) begin miss++; $display("FAIL rmid_line: got %b want 1 before next edge", o_data_out); end
    vecs++; if (o_count !== '0 || o_empty !== 1'b1) begin
      miss++; $display("FAIL rmid_fifo: count=%0d empty=%b want 0/1", o_count, o_empty);
    end
    sb.delete();
    repeat (3) @(negedge i_clk);
    i_reset = 1;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      if (o_data_out !== 1'b1) lows++;
    end
    vecs++; if (lows != 0) begin miss++; $display("FAIL rmid_idle: %0d low clocks want 0", lows); end
    vecs++; if (n_done !== d0) begin miss++; $display("FAIL rmid_done: %0d pulses want 0", n_done - d0); end
  endtask

  task automatic test_cfg_toggle();
    i_parity_en = 0; i_parity_odd = 0; i_stop2 = 0;
    wr(8'h81);
    fork
      expect_frame("tog_a", 0);
      begin
        repeat (200) @(negedge i_clk);
        i_parity_en = 1; i_parity_odd = 1; i_stop2 = 1;
        wr(8'h81);
      end
    join
    expect_frame("tog_b", 0);
    i_parity_en = 0; i_parity_odd = 0; i_stop2 = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_overflow_stall();
    test_reset_mid();
    test_cfg_toggle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
